// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and defaults for the serial byte engine.
//                Provides the engine state encoding and the default word
//                width and inter-frame gap.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

    // Engine states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_GAP   = 1;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module      : serial_byte_engine
//  Description : Full-duplex SPI mode-0 shift engine driven by externally
//                generated sclk edge strobes. Accepts a word over a
//                valid/ready handshake, frames it with active-low cs_n,
//                drives mosi on falling-edge strobes, samples miso on
//                rising-edge strobes, returns the received word with a
//                one-clk rx_valid pulse.
//  Config      : SERIAL_LSB_FIRST_EN - when defined, transmit and receive
//                LSB-first (default MSB-first). Timing is identical.
//  Ports       : clk, reset (async, active-high)
//                sclkPosEdge / sclkNegEdge  - one-clk sclk edge strobes
//                tx_data/tx_valid/tx_ready  - transmit word handshake
//                rx_data/rx_valid           - received word + pulse
//                miso/mosi/cs_n             - serial pins
//                busy                       - high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module serial_byte_engine
    import serial_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter int GAP_EDGES = c_DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclkPosEdge,
    input  logic             sclkNegEdge,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             miso,
    output logic             mosi,
    output logic             cs_n,
    output logic             busy
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(WIDTH);
    localparam logic [3:0]         c_GAP_LAST = 4'(GAP_EDGES);

    state_t             r_state;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic               r_mosi;
    logic               r_cs_n;

    // Strobes should never coincide; if they do, the rising edge wins.
    logic               w_neg;
    logic               w_tx_first;
    logic               w_tx_next;
    logic [WIDTH-1:0]   w_tx_shifted;
    logic [WIDTH-1:0]   w_rx_shifted;
    logic [3:0]         w_gap_next;

    assign w_neg      = sclkNegEdge & ~sclkPosEdge;
    assign w_gap_next = r_gap_cnt + 4'd1;

`ifdef SERIAL_LSB_FIRST_EN
    assign w_tx_first   = r_tx_shift[0];
    assign w_tx_next    = r_tx_shift[1];
    assign w_tx_shifted = {1'b0, r_tx_shift[WIDTH-1:1]};
    assign w_rx_shifted = {miso, r_rx_shift[WIDTH-1:1]};
`else
    assign w_tx_first   = r_tx_shift[WIDTH-1];
    assign w_tx_next    = r_tx_shift[WIDTH-2];
    assign w_tx_shifted = {r_tx_shift[WIDTH-2:0], 1'b0};
    assign w_rx_shifted = {r_rx_shift[WIDTH-2:0], miso};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        r_tx_shift <= tx_data;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_SETUP;
                    end
                end

                // Wait for a falling edge so the first rising edge sees
                // data that has been stable for half an sclk period.
                ST_SETUP: begin
                    if (w_neg) begin
                        r_cs_n  <= 1'b0;
                        r_mosi  <= w_tx_first;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (sclkPosEdge) begin
                        r_rx_shift <= w_rx_shifted;
                        if (r_bit_cnt != c_BIT_LAST) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_neg) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            // Falling edge after the last sample closes the frame.
                            r_cs_n     <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_gap_cnt  <= '0;
                            r_state    <= ST_GAP;
                        end else begin
                            r_tx_shift <= w_tx_shifted;
                            r_mosi     <= w_tx_next;
                        end
                    end
                end

                ST_GAP: begin
                    if (w_neg) begin
                        r_gap_cnt <= w_gap_next;
                        if (w_gap_next == c_GAP_LAST) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule : serial_byte_engine
`default_nettype wire

// File: tb/tb_serial_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_byte_engine
//  Description : Self-checking bench for serial_byte_engine. A free-running
//                divider stands in for the serial clock generator (sclk
//                period 8 clk). A simple SPI slave model shifts a word out on
//                miso, or miso is looped back from mosi.
//  Config      : SERIAL_LSB_FIRST_EN - expected bit orders follow the macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_byte_engine;

    localparam int c_WIDTH = 8;
    localparam int c_GAP   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclkPosEdge = 1'b0;
    logic       sclkNegEdge = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       miso;
    logic       mosi;
    logic       cs_n;
    logic       busy;

    serial_byte_engine #(
        .WIDTH     (c_WIDTH),
        .GAP_EDGES (c_GAP)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .miso        (miso),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Strobe source: 3-bit divider, sclk rises at count 3, falls at count 7
    logic [2:0] r_div = 3'd0;
    always @(posedge clk) begin
        r_div       <= r_div + 3'd1;
        sclkPosEdge <= (r_div == 3'd3);
        sclkNegEdge <= (r_div == 3'd7);
    end

    // Slave model: MSB of its word presented while cs_n is high, shifted on
    // each falling strobe inside the frame.
    logic       loop_en = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] r_slave_sr = 8'h00;
    always @(posedge clk) begin
        if (cs_n)
            r_slave_sr <= slave_word;
        else if (sclkNegEdge)
            r_slave_sr <= {r_slave_sr[6:0], 1'b0};
    end
    assign miso = loop_en ? mosi : r_slave_sr[7];

    // Monitor, sampled on the falling clk edge
    logic [7:0] mon_mosi;
    logic [7:0] mon_rx;
    int         mon_rises, mon_pulses, mon_gapnegs, mon_hs, mon_cs_rise;
    logic       mon_after, mon_prev_cs;
    initial mon_prev_cs = 1'b1;

    always @(negedge clk) begin
        if (!cs_n && sclkPosEdge) begin
            mon_mosi  = {mon_mosi[6:0], mosi};
            mon_rises = mon_rises + 1;
        end
        if (mon_after && busy && sclkNegEdge) mon_gapnegs = mon_gapnegs + 1;
        if (rx_valid) begin
            mon_pulses = mon_pulses + 1;
            mon_rx     = rx_data;
            mon_after  = 1'b1;
        end
        if (tx_valid && tx_ready) begin
            mon_hs    = mon_hs + 1;
            mon_after = 1'b0;
        end
        if (cs_n && !mon_prev_cs) mon_cs_rise = mon_cs_rise + 1;
        mon_prev_cs = cs_n;
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (act !== exp) begin
            miss_cnt = miss_cnt + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_mosi    = 8'h00;
        mon_rx      = 8'h00;
        mon_rises   = 0;
        mon_pulses  = 0;
        mon_gapnegs = 0;
        mon_hs      = 0;
        mon_cs_rise = 0;
        mon_after   = 1'b0;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] exp_mosi_of(input logic [7:0] v);
`ifdef SERIAL_LSB_FIRST_EN
        return rev8(v);
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] exp_rx_of(input logic [7:0] v, input logic lp);
`ifdef SERIAL_LSB_FIRST_EN
        return lp ? v : rev8(v);
`else
        return v;
`endif
    endfunction

    // One-clk handshake from IDLE
    task automatic start_word(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n >= 400), 32'd0);
    endtask

    task automatic wait_rises(input int target, input string name);
        int n = 0;
        while (mon_rises < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_rise_timeout"}, 32'(n >= 400), 32'd0);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       lp;
        logic [7:0] mw;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // MSB-first expectations; the functions above re-order for LSB-first
        vecs[0] = '{tx: 8'hA5, lp: 1'b0, mw: 8'h3C, exp_mosi: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'hC3, lp: 1'b1, mw: 8'h00, exp_mosi: 8'hC3, exp_rx: 8'hC3};
        vecs[2] = '{tx: 8'h00, lp: 1'b0, mw: 8'hFF, exp_mosi: 8'h00, exp_rx: 8'hFF};
        vecs[3] = '{tx: 8'hFF, lp: 1'b0, mw: 8'h00, exp_mosi: 8'hFF, exp_rx: 8'h00};
        vecs[4] = '{tx: 8'h01, lp: 1'b1, mw: 8'h00, exp_mosi: 8'h01, exp_rx: 8'h01};
        vecs[5] = '{tx: 8'h96, lp: 1'b0, mw: 8'h69, exp_mosi: 8'h96, exp_rx: 8'h69};

        clear_mon();
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n",     32'(cs_n),     32'd1);
        check("rst_mosi",     32'(mosi),     32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            loop_en    = vecs[i].lp;
            slave_word = vecs[i].mw;
            start_word(vecs[i].tx);
            wait_idle("vec");
            check($sformatf("vec%0d_mosi", i),   32'(mon_mosi),   32'(exp_mosi_of(vecs[i].exp_mosi)));
            check($sformatf("vec%0d_rx", i),     32'(mon_rx),     32'(exp_rx_of(vecs[i].exp_rx, vecs[i].lp)));
            check($sformatf("vec%0d_pulses", i), 32'(mon_pulses), 32'd1);
            check($sformatf("vec%0d_rises", i),  32'(mon_rises),  32'd8);
            check($sformatf("vec%0d_gap", i),    32'(mon_gapnegs), 32'(c_GAP));
            check($sformatf("vec%0d_rxhold", i), 32'(rx_data),    32'(exp_rx_of(vecs[i].exp_rx, vecs[i].lp)));
        end

        // Back-to-back with tx_valid held high
        begin
            int n = 0;
            int gap_at_hs;
            clear_mon();
            loop_en = 1'b1;
            @(negedge clk);
            tx_data  = 8'h01;
            tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            tx_data = 8'h80;
            while (mon_hs < 2 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("b2b_hs_timeout", 32'(n >= 400), 32'd0);
            gap_at_hs = mon_gapnegs;
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            wait_idle("b2b");
            check("b2b_gap_before_hs", 32'(gap_at_hs),   32'(c_GAP));
            check("b2b_pulses",        32'(mon_pulses),  32'd2);
            check("b2b_cs_rises",      32'(mon_cs_rise), 32'd2);
            check("b2b_rises",         32'(mon_rises),   32'd16);
            check("b2b_rx",            32'(mon_rx),      32'h80);
            check("b2b_mosi",          32'(mon_mosi),    32'(exp_mosi_of(8'h80)));
        end

        // tx_valid while busy is ignored
        clear_mon();
        loop_en = 1'b1;
        start_word(8'h12);
        wait_rises(3, "busy");
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        #1;
        check("busy_tx_ready", 32'(tx_ready), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h12;
        wait_idle("busy");
        repeat (24) @(negedge clk);
        check("busy_mosi",   32'(mon_mosi),   32'(exp_mosi_of(8'h12)));
        check("busy_rx",     32'(mon_rx),     32'h12);
        check("busy_hs",     32'(mon_hs),     32'd1);
        check("busy_pulses", 32'(mon_pulses), 32'd1);
        check("busy_idle",   32'(busy),       32'd0);

        // Reset mid-transfer
        clear_mon();
        loop_en    = 1'b0;
        slave_word = 8'hF0;
        start_word(8'h5A);
        wait_rises(3, "rstmid");
        @(negedge clk);
        check("rstmid_cs_low", 32'(cs_n), 32'd0);
        reset = 1'b1;
        #1;
        check("rstmid_cs_n",     32'(cs_n),     32'd1);
        check("rstmid_mosi",     32'(mosi),     32'd0);
        check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
        check("rstmid_busy",     32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid_no_pulse", 32'(mon_pulses), 32'd0);

        clear_mon();
        loop_en = 1'b1;
        start_word(8'h5A);
        wait_idle("after_rst");
        check("after_rst_rx",     32'(mon_rx),     32'h5A);
        check("after_rst_mosi",   32'(mon_mosi),   32'(exp_mosi_of(8'h5A)));
        check("after_rst_pulses", 32'(mon_pulses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_serial_byte_engine
`default_nettype wire
